ray_scan_sequencer: RTL and testbench
=====================================

# ray_scan_sequencer

Parametrised pixel-scan sequencer that replaces the fixed 128x64 scan host. It walks a COLS x ROWS frame in progressive or interlaced order and issues one trace request per pixel to the tracer core over a req/ack handshake. Each result is delivered to the frame buffer over a valid/ready stream. Per-frame left/right/front/back collision flags are accumulated and published atomically at frame end. It sits between the tracer core and the frame-buffer write port, all on `tracer_clk`.

## Interface
- COLS, 128, pixels per row (>=2)
- ROWS, 64, rows per frame (>=2, even when interlace is used)
- COL_W, 7, column address width (2^COL_W >= COLS)
- ROW_W, 6, row address width (2^ROW_W >= ROWS)
- COLOR_W, 12, pixel colour width
- EDGE_COLS, 1, width of left/right collision bands in columns
- NEAR_ROWS, 1, height of bottom (back) collision band in rows

Ports:
- tracer_clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run frames continuously while high
- interlace  in  1  scan mode; sampled only at frame start
- trace_req  out  1  request trace of (trace_col, trace_row)
- trace_col  out  COL_W  column of requested pixel
- trace_row  out  ROW_W  row of requested pixel
- trace_ack  in  1  one-cycle pulse: result valid
- trace_color  in  COLOR_W  traced colour, valid with trace_ack
- trace_hit  in  1  object within collision distance, valid with trace_ack
- pix_valid  out  1  pixel word available
- pix_ready  in  1  frame buffer accepts pixel
- pix_col  out  COL_W; pix_row  out  ROW_W; pix_color  out  COLOR_W  pixel word
- frame_done  out  1  one-cycle pulse when frame completes
- collision_sig  out  4  {left,right,front,back}, held for last completed frame
- frame_cnt  out  8  completed-frame counter, wraps 255->0
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, TRACE, EMIT, FRAME_END.
- IDLE: if enable, latch interlace into the mode register, set col=0, row=0, go to TRACE.
- TRACE: trace_req=1, coords = current col/row, stable until ack. On trace_ack, capture colour/hit/coords into the output register, update the accumulator, go to EMIT. trace_ack outside TRACE is ignored.
- EMIT: pix_valid=1, word stable until pix_ready. On transfer: if last pixel then FRAME_END, else advance scan position and go to TRACE.
- Scan advance: col+1; at col==COLS-1, col=0 and the row steps.
- Progressive row step: row+1.
- Interlaced row step: row+2; after the last even row (ROWS-2), row=1; last pixel is (COLS-1, ROWS-1) in both modes.
- Accumulator on each hit:
  - left if col<EDGE_COLS
  - right if col>=COLS-EDGE_COLS
  - front if neither left nor right
  - back if row>=ROWS-NEAR_ROWS
  - Hits are OR-ed over the frame.
- FRAME_END (one cycle): collision_sig <= accumulator (including last pixel), accumulator cleared, frame_done=1, frame_cnt+1. Next state TRACE at (0,0) with interlace re-sampled if enable, else IDLE.
- Dropping enable mid-frame does not abort; the frame completes first.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs 0: trace_req, coords, pix_valid, pix word, frame_done, collision_sig, frame_cnt, busy. Accumulator cleared.
- Reset mid-frame abandons the frame; no frame_done; collision_sig returns to 0.
- Enable high at cycle t in IDLE: trace_req=1 at t+1.
- Ack at cycle t: pix_valid=1 at t+1.
- pix_ready high at t+1: next trace_req at t+2. Minimum 2 cycles/pixel plus tracer latency.
- Last pixel transfer at cycle t: frame_done and new collision_sig visible at t+1. trace_req for the next frame at t+2 (if enable).
- pix_ready held low: pix_valid and word hold indefinitely, and no new trace_req is issued.
- trace_ack in the same cycle trace_req first rises is accepted (zero-wait tracer).
- collision_sig changes only in the FRAME_END cycle.

## Test plan
- COLS=4, ROWS=2, progressive, ack 1 cycle after every req, pix_ready=1 -> pixels (0,0)..(3,0),(0,1)..(3,1) in order. frame_done once, 2 cycles after the 8th transfer's ack; frame_cnt=1.
- COLS=4, ROWS=4, interlace=1 -> row order 0,2,1,3. Toggling interlace mid-frame has no effect until the next frame.
- hit only at (0,1) with NEAR_ROWS=1, ROWS=2 -> collision_sig=4'b1001 after frame_done. A following hit-free frame -> 4'b0000.
- pix_ready low 10 cycles during pixel (2,0) -> pix word constant, trace_req stays 0, no pixel lost or duplicated.
- enable dropped during pixel 3 of frame 0 -> frame completes, frame_done pulses, state IDLE, busy=0, no further trace_req.
- rst_n pulsed low mid-frame -> all outputs 0 immediately. After release with enable=1, scan restarts at (0,0) with frame_cnt=0.

Source files
------------

// File: rtl/ray_scan_sequencer.sv
// ray_scan_sequencer: walks a COLS x ROWS frame in progressive or interlaced
// order, issues one trace request per pixel over a req/ack handshake, streams
// each result to the frame buffer over valid/ready, and publishes per-frame
// {left,right,front,back} collision flags at frame end.
module ray_scan_sequencer #(
    parameter int COLS      = 128,
    parameter int ROWS      = 64,
    parameter int COL_W     = 7,
    parameter int ROW_W     = 6,
    parameter int COLOR_W   = 12,
    parameter int EDGE_COLS = 1,
    parameter int NEAR_ROWS = 1
) (
    input  logic               tracer_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               interlace,
    output logic               trace_req,
    output logic [COL_W-1:0]   trace_col,
    output logic [ROW_W-1:0]   trace_row,
    input  logic               trace_ack,
    input  logic [COLOR_W-1:0] trace_color,
    input  logic               trace_hit,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COL_W-1:0]   pix_col,
    output logic [ROW_W-1:0]   pix_row,
    output logic [COLOR_W-1:0] pix_color,
    output logic               frame_done,
    output logic [3:0]         collision_sig,
    output logic [7:0]         frame_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, TRACE, EMIT, FRAME_END} state_t;

    localparam logic [COL_W-1:0] LP_COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LP_ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] LP_ROW_EVEN  = ROW_W'(ROWS - 2);
    localparam logic [COL_W-1:0] LP_EDGE_LO   = COL_W'(EDGE_COLS);
    localparam logic [COL_W-1:0] LP_EDGE_HI   = COL_W'(COLS - EDGE_COLS);
    localparam logic [ROW_W-1:0] LP_NEAR_ROW  = ROW_W'(ROWS - NEAR_ROWS);

    state_t               r_state;
    state_t               w_next;
    logic                 r_mode;
    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [3:0]           r_acc;
    logic [COL_W-1:0]     r_pix_col;
    logic [ROW_W-1:0]     r_pix_row;
    logic [COLOR_W-1:0]   r_pix_color;
    logic [3:0]           r_coll;
    logic [7:0]           r_frame_cnt;

    logic                 w_ack;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_start;
    logic                 w_left;
    logic                 w_right;
    logic [3:0]           w_hit_bits;

    assign w_ack      = (r_state == TRACE) && trace_ack;
    assign w_xfer     = (r_state == EMIT) && pix_ready;
    assign w_last     = (r_col == LP_COL_LAST) && (r_row == LP_ROW_LAST);
    assign w_start    = ((r_state == IDLE) || (r_state == FRAME_END)) && enable;
    assign w_left     = (r_col < LP_EDGE_LO);
    assign w_right    = (r_col >= LP_EDGE_HI);
    assign w_hit_bits = {w_left, w_right, !w_left && !w_right, r_row >= LP_NEAR_ROW};

    // State register
    always_ff @(posedge tracer_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (enable) w_next = TRACE;
            TRACE:     if (trace_ack) w_next = EMIT;
            EMIT:      if (pix_ready) w_next = w_last ? FRAME_END : TRACE;
            FRAME_END: w_next = enable ? TRACE : IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs
    always_comb begin
        trace_req  = 1'b0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (r_state)
            IDLE:      busy       = 1'b0;
            TRACE:     trace_req  = 1'b1;
            EMIT:      pix_valid  = 1'b1;
            FRAME_END: frame_done = 1'b1;
            default:   busy       = 1'b0;
        endcase
    end

    // Scan position, pixel word capture, collision accumulation and publish
    always_ff @(posedge tracer_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_acc       <= '0;
            r_pix_col   <= '0;
            r_pix_row   <= '0;
            r_pix_color <= '0;
            r_coll      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (w_start) begin
                r_mode <= interlace;
                r_col  <= '0;
                r_row  <= '0;
            end
            if (w_ack) begin
                r_pix_col   <= r_col;
                r_pix_row   <= r_row;
                r_pix_color <= trace_color;
                if (trace_hit) begin
                    r_acc <= r_acc | w_hit_bits;
                end
            end
            if (w_xfer) begin
                if (w_last) begin
                    // Published on the last transfer edge so the new flags and
                    // count are visible exactly in the FRAME_END cycle.
                    r_coll      <= r_acc;
                    r_acc       <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else if (r_col == LP_COL_LAST) begin
                    r_col <= '0;
                    if (!r_mode) begin
                        r_row <= r_row + ROW_W'(1);
                    end else if (r_row == LP_ROW_EVEN) begin
                        r_row <= ROW_W'(1);
                    end else begin
                        r_row <= r_row + ROW_W'(2);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign trace_col     = r_col;
    assign trace_row     = r_row;
    assign pix_col       = r_pix_col;
    assign pix_row       = r_pix_row;
    assign pix_color     = r_pix_color;
    assign collision_sig = r_coll;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_ray_scan_sequencer.sv
// tb_ray_scan_sequencer: table-driven frames on a 4x4 sequencer plus
// hand-written enable-drop and mid-frame reset sequences.
module tb_ray_scan_sequencer;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        interlace;
    logic        trace_req;
    logic [1:0]  trace_col;
    logic [1:0]  trace_row;
    logic        trace_ack;
    logic [11:0] trace_color;
    logic        trace_hit;
    logic        pix_valid;
    logic        pix_ready;
    logic [1:0]  pix_col;
    logic [1:0]  pix_row;
    logic [11:0] pix_color;
    logic        frame_done;
    logic [3:0]  collision_sig;
    logic [7:0]  frame_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    ray_scan_sequencer #(
        .COLS(4), .ROWS(4), .COL_W(2), .ROW_W(2),
        .COLOR_W(12), .EDGE_COLS(1), .NEAR_ROWS(1)
    ) dut (
        .tracer_clk(clk), .rst_n(rst_n), .enable(enable), .interlace(interlace),
        .trace_req(trace_req), .trace_col(trace_col), .trace_row(trace_row),
        .trace_ack(trace_ack), .trace_color(trace_color), .trace_hit(trace_hit),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_col(pix_col),
        .pix_row(pix_row), .pix_color(pix_color), .frame_done(frame_done),
        .collision_sig(collision_sig), .frame_cnt(frame_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame of stimulus: scan order, hits, stall/drop/abort points, results
    typedef struct {
        logic            ilace;
        logic [3:0][1:0] rows;      // rows[i] = i-th scanned row
        int              hc0, hr0;  // hit pixel 0 (-1 = none)
        int              hc1, hr1;  // hit pixel 1 (-1 = none)
        int              stall_idx; // pixel index with pix_ready held low
        int              drop_idx;  // pixel index at which enable drops
        int              abort_idx; // pixel index after which the task returns
        logic [3:0]      exp_coll;
        logic [7:0]      exp_cnt;
    } frame_vec_t;

    frame_vec_t tbl [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic run_frame(input int f);
        int         c, r, n;
        int         lat;
        logic       hit;
        logic [11:0] colv;
        for (int p = 0; p < 16; p++) begin
            c = p % 4;
            r = int'(tbl[f].rows[p / 4]);
            n = 0;
            while (!trace_req && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("req_seen", 32'(trace_req), 1);
            if (!trace_req) return;
            if (p > 0) check("req_latency", n, 0);
            check("trace_col", 32'(trace_col), 32'(c));
            check("trace_row", 32'(trace_row), 32'(r));
            check("busy_trace", 32'(busy), 1);
            lat = (p % 3 == 1) ? 2 : 0;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                check("req_hold", 32'(trace_req), 1);
                check("req_col_hold", 32'(trace_col), 32'(c));
            end
            colv = 12'(f * 256 + p * 7 + 1);
            hit  = ((c == tbl[f].hc0) && (r == tbl[f].hr0)) ||
                   ((c == tbl[f].hc1) && (r == tbl[f].hr1));
            trace_ack   = 1'b1;
            trace_color = colv;
            trace_hit   = hit;
            @(negedge clk);
            trace_ack   = 1'b0;
            trace_hit   = 1'b0;
            trace_color = 12'hFFF;
            check("pix_valid", 32'(pix_valid), 1);
            check("req_drop", 32'(trace_req), 0);
            check("pix_col", 32'(pix_col), 32'(c));
            check("pix_row", 32'(pix_row), 32'(r));
            check("pix_color", 32'(pix_color), 32'(colv));
            if (p == tbl[f].abort_idx) return;
            if (p == tbl[f].stall_idx) begin
                for (int i = 0; i < 10; i++) begin
                    // Stray ack while waiting on the frame buffer must be ignored
                    if (i == 3) begin
                        trace_ack   = 1'b1;
                        trace_hit   = 1'b1;
                        trace_color = 12'hABC;
                    end
                    @(negedge clk);
                    trace_ack = 1'b0;
                    trace_hit = 1'b0;
                    check("stall_valid", 32'(pix_valid), 1);
                    check("stall_req", 32'(trace_req), 0);
                    check("stall_color", 32'(pix_color), 32'(colv));
                end
            end
            if (p == tbl[f].drop_idx) enable = 1'b0;
            if (p == 5 && f + 1 < 6) interlace = tbl[f + 1].ilace;
            pix_ready = 1'b1;
            @(negedge clk);
            pix_ready = 1'b0;
            if (p < 15) check("no_done_mid", 32'(frame_done), 0);
        end
        check("frame_done", 32'(frame_done), 1);
        check("collision_sig", 32'(collision_sig), 32'(tbl[f].exp_coll));
        check("frame_cnt", 32'(frame_cnt), 32'(tbl[f].exp_cnt));
        check("end_req", 32'(trace_req), 0);
        @(negedge clk);
        check("done_pulse", 32'(frame_done), 0);
        check("next_req", 32'(trace_req), 32'(enable));
        check("coll_hold", 32'(collision_sig), 32'(tbl[f].exp_coll));
    endtask

    initial begin
        //         ilace rows                          hc0 hr0 hc1 hr1 stall drop abort coll     cnt
        tbl[0] = '{1'b0, {2'd3,2'd2,2'd1,2'd0},  0,  3, -1, -1,  -1,  -1,  -1, 4'b1001, 8'd1};
        tbl[1] = '{1'b1, {2'd3,2'd1,2'd2,2'd0}, -1, -1, -1, -1,   2,  -1,  -1, 4'b0000, 8'd2};
        tbl[2] = '{1'b0, {2'd3,2'd2,2'd1,2'd0},  2,  1,  3,  2,  -1,  -1,  -1, 4'b0110, 8'd3};
        tbl[3] = '{1'b1, {2'd3,2'd1,2'd2,2'd0},  3,  3, -1, -1,  -1,   3,  -1, 4'b0101, 8'd4};
        tbl[4] = '{1'b0, {2'd3,2'd2,2'd1,2'd0},  1,  0, -1, -1,  -1,  -1,   5, 4'b0000, 8'd0};
        tbl[5] = '{1'b0, {2'd3,2'd2,2'd1,2'd0}, -1, -1, -1, -1,  -1,  -1,  -1, 4'b0000, 8'd1};

        rst_n = 1'b0; enable = 1'b0; interlace = 1'b0;
        trace_ack = 1'b0; trace_color = '0; trace_hit = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(trace_req), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_coll", 32'(collision_sig), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(trace_req), 0);

        interlace = tbl[0].ilace;
        enable    = 1'b1;
        @(negedge clk);
        check("enable_to_req", 32'(trace_req), 1);
        for (int f = 0; f < 4; f++) run_frame(f);

        // Enable dropped in frame 3: sequencer rests in IDLE
        for (int i = 0; i < 5; i++) begin
            if (i == 1) trace_ack = 1'b1;
            @(negedge clk);
            trace_ack = 1'b0;
            check("idle_req", 32'(trace_req), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_valid", 32'(pix_valid), 0);
        end
        check("idle_cnt", 32'(frame_cnt), 4);

        // Restart, then reset mid-frame while a pixel word is pending
        interlace = tbl[4].ilace;
        enable    = 1'b1;
        @(negedge clk);
        check("restart_req", 32'(trace_req), 1);
        run_frame(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(trace_req), 0);
        check("mid_rst_col", 32'(trace_col), 0);
        check("mid_rst_row", 32'(trace_row), 0);
        check("mid_rst_valid", 32'(pix_valid), 0);
        check("mid_rst_pcol", 32'(pix_col), 0);
        check("mid_rst_prow", 32'(pix_row), 0);
        check("mid_rst_color", 32'(pix_color), 0);
        check("mid_rst_coll", 32'(collision_sig), 0);
        check("mid_rst_cnt", 32'(frame_cnt), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(trace_req), 1);
        run_frame(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
